// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : loader_pkg
//  Description : Shared definitions for the memory loader. Holds the status
//                encodings seen by the core/selector and the loader FSM state
//                enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
package loader_pkg;

    // Core/selector mode reported on the status port
    localparam logic [1:0] c_STATUS_IDLE = 2'b00;
    localparam logic [1:0] c_STATUS_LOAD = 2'b01;
    localparam logic [1:0] c_STATUS_RUN  = 2'b10;
    localparam logic [1:0] c_STATUS_DUMP = 2'b11;

    // Loader FSM states
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LOAD_LO = 4'd1,
        LOAD_HI = 4'd2,
        WRITE   = 4'd3,
        RUN     = 4'd4,
        DUMP_RD = 4'd5,
        DUMP_LO = 4'd6,
        DUMP_HI = 4'd7,
        FINISH  = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Byte <-> 16-bit word conversion (little-endian). Assembles a
//                word from low/high byte strobes, or captures a whole word
//                and presents its low or high byte.
//  Ports       : clk, rst          - clock, async active-high reset
//                i_byte            - incoming byte
//                i_load_lo/hi      - latch i_byte into the low/high half
//                i_word/i_load_word- capture a whole word (takes priority)
//                i_sel_hi          - select high byte on o_byte
//                o_word            - held word
//                o_byte            - selected byte of the held word
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_byte,
    input  logic        i_load_lo,
    input  logic        i_load_hi,
    input  logic [15:0] i_word,
    input  logic        i_load_word,
    input  logic        i_sel_hi,
    output logic [15:0] o_word,
    output logic [7:0]  o_byte
);

    logic [15:0] r_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word <= 16'h0000;
        end else if (i_load_word) begin
            r_word <= i_word;
        end else begin
            if (i_load_lo) r_word[7:0]  <= i_byte;
            if (i_load_hi) r_word[15:8] <= i_byte;
        end
    end

    assign o_word = r_word;
    assign o_byte = i_sel_hi ? r_word[15:8] : r_word[7:0];

endmodule
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mem_loader
//  Description : Loads N_WORDS little-endian 16-bit words from a serial byte
//                stream into data memory, lets the cores run until
//                end_process, then (optionally) dumps the memory back out
//                byte by byte and pulses done.
//  Config      : MEM_LOADER_DUMP_EN - when defined, the dump phase is built;
//                otherwise RUN goes straight to FINISH and tx_* stay 0.
//  Ports       : clk, rst (async, active-high)
//                start                - begin a sequence (IDLE only)
//                rx_data/rx_valid     - incoming bytes
//                end_process          - cores finished (RUN only)
//                com_data_out         - memory read data (1-cycle latency)
//                tx_ready             - transmitter accepts a byte
//                status               - IDLE/LOAD/RUN/DUMP mode
//                com_data_in/com_addr/com_wr_en - memory write/read port
//                tx_data/tx_valid     - outgoing bytes
//                done                 - one-cycle end-of-sequence pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_loader
    import loader_pkg::*;
#(
    parameter logic [15:0] N_WORDS   = 16'd256,
    parameter logic [15:0] BASE_ADDR = 16'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        end_process,
    input  logic [15:0] com_data_out,
    input  logic        tx_ready,
    output logic [1:0]  status,
    output logic [15:0] com_data_in,
    output logic [15:0] com_addr,
    output logic        com_wr_en,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        done
);

    localparam logic [15:0] c_LAST_INDEX = N_WORDS - 16'd1;

    state_t      r_state;
    logic [1:0]  r_status;
    logic [15:0] r_addr;
    logic        r_wr_en;
    logic        r_tx_valid;
    logic        r_done;
    logic [15:0] r_index;

    logic        w_more;
    logic        w_load_lo;
    logic        w_load_hi;
    logic        w_load_word;
    logic        w_sel_hi;
    logic [15:0] w_word;
    logic [7:0]  w_byte;

    assign w_more    = (r_index < c_LAST_INDEX);
    assign w_load_lo = (r_state == LOAD_LO) && rx_valid;
    assign w_load_hi = (r_state == LOAD_HI) && rx_valid;

`ifdef MEM_LOADER_DUMP_EN
    // The read issued in DUMP_RD returns while in DUMP_LO; capture it on the
    // first DUMP_LO cycle, which is the one where tx_valid is still low.
    assign w_load_word = (r_state == DUMP_LO) && !r_tx_valid;
    assign w_sel_hi    = (r_state == DUMP_HI);
`else
    assign w_load_word = 1'b0;
    assign w_sel_hi    = 1'b0;
`endif

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_byte      (rx_data),
        .i_load_lo   (w_load_lo),
        .i_load_hi   (w_load_hi),
        .i_word      (com_data_out),
        .i_load_word (w_load_word),
        .i_sel_hi    (w_sel_hi),
        .o_word      (w_word),
        .o_byte      (w_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_status   <= c_STATUS_IDLE;
            r_addr     <= 16'h0000;
            r_wr_en    <= 1'b0;
            r_tx_valid <= 1'b0;
            r_done     <= 1'b0;
            r_index    <= 16'h0000;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= LOAD_LO;
                        r_status <= c_STATUS_LOAD;
                        r_index  <= 16'h0000;
                    end
                end
                LOAD_LO: begin
                    if (rx_valid) r_state <= LOAD_HI;
                end
                LOAD_HI: begin
                    // Write strobe and address are registered here so they
                    // are valid for exactly the one WRITE cycle.
                    if (rx_valid) begin
                        r_state <= WRITE;
                        r_wr_en <= 1'b1;
                        r_addr  <= BASE_ADDR + r_index;
                    end
                end
                WRITE: begin
                    if (w_more) begin
                        r_index <= r_index + 16'd1;
                        r_state <= LOAD_LO;
                    end else begin
                        r_state  <= RUN;
                        r_status <= c_STATUS_RUN;
                    end
                end
                RUN: begin
                    if (end_process) begin
`ifdef MEM_LOADER_DUMP_EN
                        r_state  <= DUMP_RD;
                        r_status <= c_STATUS_DUMP;
                        r_index  <= 16'h0000;
                        r_addr   <= BASE_ADDR;
`else
                        r_state  <= FINISH;
                        r_status <= c_STATUS_IDLE;
                        r_done   <= 1'b1;
`endif
                    end
                end
`ifdef MEM_LOADER_DUMP_EN
                DUMP_RD: begin
                    r_state <= DUMP_LO;
                end
                DUMP_LO: begin
                    // tx_valid stays high across the LO->HI handoff; the
                    // byte mux switches to the high byte with the state.
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                    end else if (tx_ready) begin
                        r_state <= DUMP_HI;
                    end
                end
                DUMP_HI: begin
                    if (tx_ready) begin
                        r_tx_valid <= 1'b0;
                        if (w_more) begin
                            r_index <= r_index + 16'd1;
                            r_addr  <= BASE_ADDR + r_index + 16'd1;
                            r_state <= DUMP_RD;
                        end else begin
                            r_state  <= FINISH;
                            r_status <= c_STATUS_IDLE;
                            r_done   <= 1'b1;
                        end
                    end
                end
`endif
                FINISH: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state  <= IDLE;
                    r_status <= c_STATUS_IDLE;
                end
            endcase
        end
    end

    assign status      = r_status;
    assign com_addr    = r_addr;
    assign com_wr_en   = r_wr_en;
    assign com_data_in = w_word;
    assign done        = r_done;
    assign tx_valid    = r_tx_valid;

`ifdef MEM_LOADER_DUMP_EN
    assign tx_data = r_tx_valid ? w_byte : 8'h00;
`else
    assign tx_data = 8'h00;
    logic w_unused;
    assign w_unused = &{1'b0, tx_ready, w_byte};
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_loader
//  Description : Self-checking bench for mem_loader (N_WORDS=2,
//                BASE_ADDR=16'h0010). Memory writes and transmitted bytes are
//                compared against scoreboard queues by a negedge monitor;
//                mode/reset/done behaviour is checked inline. Dump checks
//                are built when MEM_LOADER_DUMP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

    localparam logic [15:0] N_WORDS   = 16'd2;
    localparam logic [15:0] BASE_ADDR = 16'h0010;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        end_process;
    logic [15:0] com_data_out;
    logic        tx_ready;
    logic [1:0]  status;
    logic [15:0] com_data_in;
    logic [15:0] com_addr;
    logic        com_wr_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        done;

    int n_checks   = 0;
    int n_errors   = 0;
    int done_count = 0;

    logic [31:0] wr_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] r_wexp;
    logic [7:0]  r_texp;
    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    mem_loader #(
        .N_WORDS   (N_WORDS),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .end_process  (end_process),
        .com_data_out (com_data_out),
        .tx_ready     (tx_ready),
        .status       (status),
        .com_data_in  (com_data_in),
        .com_addr     (com_addr),
        .com_wr_en    (com_wr_en),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .done         (done)
    );

    // Synchronous memory with one-cycle read latency
    always @(posedge clk) begin
        if (com_wr_en) mem[com_addr[7:0]] <= com_data_in;
        com_data_out <= mem[com_addr[7:0]];
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (com_wr_en) begin
                n_checks++;
                if (wr_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL mem_write: got %h@%h, expected no write", com_data_in, com_addr);
                end else begin
                    r_wexp = wr_q.pop_front();
                    if ({com_addr, com_data_in} !== r_wexp) begin
                        n_errors++;
                        $display("FAIL mem_write: got %h@%h, expected %h@%h",
                                 com_data_in, com_addr, r_wexp[15:0], r_wexp[31:16]);
                    end
                end
            end
            if (tx_valid && tx_ready) begin
                n_checks++;
                if (tx_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL tx_byte: got %h, expected no byte", tx_data);
                end else begin
                    r_texp = tx_q.pop_front();
                    if (tx_data !== r_texp) begin
                        n_errors++;
                        $display("FAIL tx_byte: got %h, expected %h", tx_data, r_texp);
                    end
                end
            end
            if (done) done_count++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_status(input logic [1:0] want, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (status === want) break;
            tick();
        end
        check(name, {30'd0, status}, {30'd0, want});
    endtask

    task automatic wait_done(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) break;
            tick();
        end
        check(name, {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        rx_data     = 8'h00;
        rx_valid    = 1'b0;
        end_process = 1'b0;
        tx_ready    = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst_status",      {30'd0, status},    32'd0);
        check("rst_wr_en",       {31'd0, com_wr_en}, 32'd0);
        check("rst_addr",        {16'd0, com_addr},  32'd0);
        check("rst_data_in",     {16'd0, com_data_in}, 32'd0);
        check("rst_tx_valid",    {31'd0, tx_valid},  32'd0);
        check("rst_tx_data",     {24'd0, tx_data},   32'd0);
        check("rst_done",        {31'd0, done},      32'd0);
        rst = 1'b0;
        tick();

        // ---------------- Sequence A: load 1234/ABCD ----------------
        wr_q.push_back({16'h0010, 16'h1234});
        wr_q.push_back({16'h0011, 16'hABCD});
`ifdef MEM_LOADER_DUMP_EN
        tx_q.push_back(8'h34); tx_q.push_back(8'h12);
        tx_q.push_back(8'hCD); tx_q.push_back(8'hAB);
`endif
        pulse_start();
        check("status_load", {30'd0, status}, 32'd1);
        end_process = 1'b1;           // must be ignored while loading
        send_byte(8'h34);
        check("load_ignores_end_process", {30'd0, status}, 32'd1);
        send_byte(8'h12);
        end_process = 1'b0;
        send_byte(8'hCD);
        send_byte(8'hAB);
        wait_status(2'b10, 20, "reach_run_a");
        check("writes_done_a", wr_q.size(), 32'd0);

        pulse_start();                // ignored in RUN
        check("start_ignored_in_run", {30'd0, status}, 32'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("run_hold", {30'd0, status}, 32'd2);
        end
        end_process = 1'b1;
        tick();
`ifdef MEM_LOADER_DUMP_EN
        check("run_exit_a", {30'd0, status}, 32'd3);
`else
        check("run_exit_a", {30'd0, status}, 32'd0);
        check("nodump_done_next", {31'd0, done}, 32'd1);
        check("nodump_tx_valid", {31'd0, tx_valid}, 32'd0);
`endif
        end_process = 1'b0;
        wait_done(60, "done_a");
        tick();
        tick();
        check("done_count_a", done_count, 32'd1);
        check("status_idle_a", {30'd0, status}, 32'd0);

        // ---------------- Sequence B: reset mid-load ----------------
        wr_q.push_back({16'h0010, 16'h2211});
        pulse_start();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("midload_status", {30'd0, status}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_status", {30'd0, status},    32'd0);
        check("midrst_wr_en",  {31'd0, com_wr_en}, 32'd0);
        check("midrst_addr",   {16'd0, com_addr},  32'd0);
        check("midrst_data",   {16'd0, com_data_in}, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Reload from BASE_ADDR
        wr_q.push_back({16'h0010, 16'hBEEF});
        wr_q.push_back({16'h0011, 16'hF00D});
`ifdef MEM_LOADER_DUMP_EN
        tx_q.push_back(8'hEF); tx_q.push_back(8'hBE);
        tx_q.push_back(8'h0D); tx_q.push_back(8'hF0);
`endif
        pulse_start();
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'h0D);
        send_byte(8'hF0);
        wait_status(2'b10, 20, "reach_run_b");
        check("writes_done_b", wr_q.size(), 32'd0);

        tx_ready    = 1'b0;
        end_process = 1'b1;
        tick();
        end_process = 1'b0;
`ifdef MEM_LOADER_DUMP_EN
        check("run_exit_b", {30'd0, status}, 32'd3);
        for (int i = 0; i < 10; i++) begin
            if (tx_valid === 1'b1) break;
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check("stall_tx_valid", {31'd0, tx_valid}, 32'd1);
            check("stall_tx_data",  {24'd0, tx_data},  32'h0000_00EF);
            tick();
        end
        tx_ready = 1'b1;
        tick();
        check("hi_byte_after_stall", {24'd0, tx_data}, 32'h0000_00BE);
`else
        check("run_exit_b", {30'd0, status}, 32'd0);
        check("nodump_done_b", {31'd0, done}, 32'd1);
        check("nodump_tx_valid_b", {31'd0, tx_valid}, 32'd0);
`endif
        wait_done(60, "done_b");
        tick();
        tick();
        check("done_count_b", done_count, 32'd2);
        check("tx_all_sent", tx_q.size(), 32'd0);
        check("tx_valid_idle", {31'd0, tx_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
